// File: rtl/egk_arb_pkg.sv
// Shared types and sizing helpers for the EGk engine round-robin arbiter.
package egk_arb_pkg;

    localparam int unsigned K_BITS   = 4;
    localparam int unsigned LEN_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Requester index width; a single requester still needs one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Watchdog counter width, wide enough to hold the abort threshold.
    function automatic int unsigned cnt_w_f(input int unsigned timeout);
        return 32'($clog2(timeout + 32'd1));
    endfunction

endpackage

// File: rtl/egk_arbiter_if.sv
// Request, engine and response signal bundle of the EGk arbiter.
interface egk_arbiter_if
    import egk_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SYMBOL_BITS = 16,
    parameter int unsigned MAX_BITS    = 16
);

    localparam int unsigned IDW = idw_f(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ*SYMBOL_BITS-1:0] req_symbol;
    logic [N_REQ*K_BITS-1:0]      req_k;

    logic                         eng_start;
    logic [SYMBOL_BITS-1:0]       eng_symbol;
    logic [K_BITS-1:0]            eng_k;
    logic                         eng_done;
    logic [MAX_BITS-1:0]          eng_code;
    logic [LEN_BITS-1:0]          eng_code_len;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [IDW-1:0]               rsp_id;
    logic [MAX_BITS-1:0]          rsp_code;
    logic [LEN_BITS-1:0]          rsp_len;
    logic                         rsp_timeout;

    logic                         busy;

    modport slave (
        input  req_valid, req_symbol, req_k,
        input  eng_done, eng_code, eng_code_len,
        input  rsp_ready,
        output req_ready,
        output eng_start, eng_symbol, eng_k,
        output rsp_valid, rsp_id, rsp_code, rsp_len, rsp_timeout,
        output busy
    );

    modport master (
        output req_valid, req_symbol, req_k,
        output eng_done, eng_code, eng_code_len,
        output rsp_ready,
        input  req_ready,
        input  eng_start, eng_symbol, eng_k,
        input  rsp_valid, rsp_id, rsp_code, rsp_len, rsp_timeout,
        input  busy
    );

endinterface

// File: rtl/egk_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module egk_rr_pick
    import egk_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDW   = idw_f(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_grant_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]   gnt_idx_o,
    output logic             any_o
);

    logic [IDW-1:0] cand;

    // Scan offsets 1..N_REQ so last_grant itself has the lowest priority.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDW'((32'(last_grant_i) + off) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                gnt_idx_o       = cand;
                gnt_oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egk_arbiter.sv
// Shares one EGk encoder engine among N_REQ binarizers: round-robin grant,
// single-cycle engine start, watchdog on done, valid/ready response.
module egk_arbiter
    import egk_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SYMBOL_BITS = 16,
    parameter int unsigned MAX_BITS    = 16,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic          clk,
    input logic          rst_n,
    egk_arbiter_if.slave arb_if
);

    localparam int unsigned IDW   = idw_f(N_REQ);
    localparam int unsigned CNT_W = cnt_w_f(TIMEOUT);

    arb_state_e             state_q, state_d;
    logic [IDW-1:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   eng_start_q, eng_start_d;
    logic [SYMBOL_BITS-1:0] eng_symbol_q, eng_symbol_d;
    logic [K_BITS-1:0]      eng_k_q, eng_k_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [MAX_BITS-1:0]    rsp_code_q, rsp_code_d;
    logic [LEN_BITS-1:0]    rsp_len_q, rsp_len_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       req_ready_c;
    logic [N_REQ-1:0]       gnt_oh;
    logic [IDW-1:0]         gnt_idx;
    logic                   any_valid;

    egk_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i        (arb_if.req_valid),
        .last_grant_i (last_grant_q),
        .gnt_oh_o     (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any_valid)
    );

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        eng_start_d   = 1'b0;
        eng_symbol_d  = eng_symbol_q;
        eng_k_d       = eng_k_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_code_d    = rsp_code_q;
        rsp_len_d     = rsp_len_q;
        rsp_timeout_d = rsp_timeout_q;
        busy_d        = busy_q;
        req_ready_c   = '0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_c  = gnt_oh;
                    eng_symbol_d = arb_if.req_symbol[32'(gnt_idx) * SYMBOL_BITS +: SYMBOL_BITS];
                    eng_k_d      = arb_if.req_k[32'(gnt_idx) * K_BITS +: K_BITS];
                    rsp_id_d     = gnt_idx;
                    last_grant_d = gnt_idx;
                    eng_start_d  = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done on the last permitted cycle still counts as a result.
                if (arb_if.eng_done) begin
                    rsp_code_d    = arb_if.eng_code;
                    rsp_len_d     = arb_if.eng_code_len;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_code_d    = '0;
                    rsp_len_d     = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (arb_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(N_REQ - 1);
            cnt_q         <= '0;
            eng_start_q   <= 1'b0;
            eng_symbol_q  <= '0;
            eng_k_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_code_q    <= '0;
            rsp_len_q     <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            eng_start_q   <= eng_start_d;
            eng_symbol_q  <= eng_symbol_d;
            eng_k_q       <= eng_k_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_code_q    <= rsp_code_d;
            rsp_len_q     <= rsp_len_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign arb_if.req_ready   = req_ready_c;
    assign arb_if.eng_start   = eng_start_q;
    assign arb_if.eng_symbol  = eng_symbol_q;
    assign arb_if.eng_k       = eng_k_q;
    assign arb_if.rsp_valid   = rsp_valid_q;
    assign arb_if.rsp_id      = rsp_id_q;
    assign arb_if.rsp_code    = rsp_code_q;
    assign arb_if.rsp_len     = rsp_len_q;
    assign arb_if.rsp_timeout = rsp_timeout_q;
    assign arb_if.busy        = busy_q;

endmodule

// File: tb/tb_egk_arbiter.sv
// Directed bench for egk_arbiter: table of transactions plus reset corner cases.
module tb_egk_arbiter;

    localparam int N  = 4;
    localparam int SB = 16;
    localparam int MB = 16;
    localparam int TO = 8;
    localparam int NV = 15;

    typedef struct {
        logic        rst_before;
        logic [3:0]  valid;
        int          exp_id;
        logic [15:0] sym;
        logic [3:0]  k;
        int          lat;          // 0: engine never answers
        int          stall;        // RESP cycles with rsp_ready low
        logic        exp_timeout;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checks = 0;
    int    errors = 0;
    string ctx;
    vec_t  vecs[NV];

    egk_arbiter_if #(.N_REQ(N), .SYMBOL_BITS(SB), .MAX_BITS(MB)) arb_if ();

    egk_arbiter #(
        .N_REQ       (N),
        .SYMBOL_BITS (SB),
        .MAX_BITS    (MB),
        .TIMEOUT     (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (arb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", ctx, name, act, exp);
        end
    endtask

    // Reference EGk encoder: code is s + 2^k, length 2*floor(log2(s+2^k)) + 1 - k.
    function automatic void egk_model(input logic [15:0] s, input logic [3:0] k,
                                      output logic [15:0] code, output logic [7:0] len);
        int unsigned v;
        int unsigned n;
        v = 32'(s) + (32'd1 << k);
        n = 0;
        for (int b = 0; b < 32; b++) if (v[b]) n = 32'(b);
        code = 16'(v);
        len  = 8'(2 * n + 1 - 32'(k));
    endfunction

    task automatic chk_reset_vals();
        chk("req_ready",   32'(arb_if.req_ready),   32'd0);
        chk("eng_start",   32'(arb_if.eng_start),   32'd0);
        chk("eng_symbol",  32'(arb_if.eng_symbol),  32'd0);
        chk("eng_k",       32'(arb_if.eng_k),       32'd0);
        chk("rsp_valid",   32'(arb_if.rsp_valid),   32'd0);
        chk("rsp_id",      32'(arb_if.rsp_id),      32'd0);
        chk("rsp_code",    32'(arb_if.rsp_code),    32'd0);
        chk("rsp_len",     32'(arb_if.rsp_len),     32'd0);
        chk("rsp_timeout", 32'(arb_if.rsp_timeout), 32'd0);
        chk("busy",        32'(arb_if.busy),        32'd0);
    endtask

    task automatic do_reset();
        arb_if.req_valid = '0;
        arb_if.eng_done  = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ctx = "reset";
        chk_reset_vals();
    endtask

    task automatic run_txn(input vec_t v, input int n);
        logic [15:0] ecode, xcode;
        logic [7:0]  elen, xlen;
        int          done_c;
        ctx = $sformatf("v%0d", n);
        for (int i = 0; i < N; i++) begin
            arb_if.req_symbol[i*SB +: SB] = (i == v.exp_id) ? v.sym : ~v.sym;
            arb_if.req_k[i*4 +: 4]        = (i == v.exp_id) ? v.k : ~v.k;
        end
        arb_if.req_valid = v.valid;
        egk_model(v.sym, v.k, ecode, elen);
        xcode  = v.exp_timeout ? 16'd0 : ecode;
        xlen   = v.exp_timeout ? 8'd0 : elen;
        done_c = (v.lat == 0) ? -1 : 1 + v.lat;
        #1;
        chk("c0 req_ready", 32'(arb_if.req_ready), 32'd1 << v.exp_id);
        chk("c0 busy",      32'(arb_if.busy),      32'd0);
        chk("c0 rsp_valid", 32'(arb_if.rsp_valid), 32'd0);
        chk("c0 eng_start", 32'(arb_if.eng_start), 32'd0);
        step();
        // A done while issuing must be ignored.
        arb_if.eng_done     = 1'b1;
        arb_if.eng_code     = 16'hBAD1;
        arb_if.eng_code_len = 8'hBB;
        #1;
        chk("c1 eng_start",  32'(arb_if.eng_start),  32'd1);
        chk("c1 eng_symbol", 32'(arb_if.eng_symbol), 32'(v.sym));
        chk("c1 eng_k",      32'(arb_if.eng_k),      32'(v.k));
        chk("c1 busy",       32'(arb_if.busy),       32'd1);
        chk("c1 req_ready",  32'(arb_if.req_ready),  32'd0);
        for (int c = 2; c <= TO + 1; c++) begin
            step();
            arb_if.eng_done     = (c == done_c);
            arb_if.eng_code     = (c == done_c) ? ecode : (16'hDEAD ^ 16'(c));
            arb_if.eng_code_len = (c == done_c) ? elen : 8'hEE;
            #1;
            chk("wait eng_start",  32'(arb_if.eng_start),  32'd0);
            chk("wait rsp_valid",  32'(arb_if.rsp_valid),  32'd0);
            chk("wait req_ready",  32'(arb_if.req_ready),  32'd0);
            chk("wait eng_symbol", 32'(arb_if.eng_symbol), 32'(v.sym));
            if (c == done_c) break;
        end
        for (int s = 0; s <= v.stall; s++) begin
            step();
            arb_if.eng_done     = 1'b1;
            arb_if.eng_code     = 16'hC0DE ^ 16'(s);
            arb_if.eng_code_len = 8'h77;
            arb_if.rsp_ready    = (s == v.stall);
            #1;
            chk("rsp_valid",   32'(arb_if.rsp_valid),   32'd1);
            chk("rsp_id",      32'(arb_if.rsp_id),      32'(v.exp_id));
            chk("rsp_code",    32'(arb_if.rsp_code),    32'(xcode));
            chk("rsp_len",     32'(arb_if.rsp_len),     32'(xlen));
            chk("rsp_timeout", 32'(arb_if.rsp_timeout), 32'(v.exp_timeout));
            chk("rsp req_ready", 32'(arb_if.req_ready), 32'd0);
            chk("rsp eng_start", 32'(arb_if.eng_start), 32'd0);
        end
        step();
        arb_if.eng_done  = 1'b0;
        arb_if.rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 4'b0100, 2, 16'd5,    4'd1, 3, 0,  1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 0, 16'd0,    4'd0, 1, 0,  1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1, 16'd1,    4'd0, 2, 0,  1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 2, 16'd6,    4'd2, 3, 0,  1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 3, 16'd20,   4'd3, 4, 0,  1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 0, 16'd100,  4'd1, 5, 0,  1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 1, 16'd255,  4'd4, 6, 0,  1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 2, 16'd2,    4'd0, 7, 0,  1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 3, 16'd30,   4'd2, 1, 10, 1'b0};
        vecs[9]  = '{1'b0, 4'b0010, 1, 16'd7,    4'd1, 0, 0,  1'b1};
        vecs[10] = '{1'b0, 4'b1001, 3, 16'd12,   4'd0, 2, 0,  1'b0};
        vecs[11] = '{1'b0, 4'b0101, 0, 16'd40,   4'd3, 8, 0,  1'b0};
        vecs[12] = '{1'b0, 4'b1010, 1, 16'd9,    4'd2, 1, 0,  1'b0};
        vecs[13] = '{1'b0, 4'b1010, 3, 16'd3,    4'd1, 4, 0,  1'b0};
        vecs[14] = '{1'b0, 4'b0001, 0, 16'd1000, 4'd4, 2, 2,  1'b0};

        rst_n               = 1'b0;
        arb_if.req_valid    = '0;
        arb_if.req_symbol   = '0;
        arb_if.req_k        = '0;
        arb_if.eng_done     = 1'b0;
        arb_if.eng_code     = '0;
        arb_if.eng_code_len = '0;
        arb_if.rsp_ready    = 1'b1;
        step();
        step();
        ctx = "por";
        chk_reset_vals();
        rst_n = 1'b1;

        for (int n = 0; n < NV; n++) begin
            if (vecs[n].rst_before) do_reset();
            run_txn(vecs[n], n);
        end

        // Reset in the middle of WAIT, then a stale done from the engine.
        ctx = "rst_wait";
        arb_if.req_symbol[2*SB +: SB] = 16'd3;
        arb_if.req_k[2*4 +: 4]        = 4'd0;
        arb_if.req_valid              = 4'b0100;
        #1;
        chk("grant", 32'(arb_if.req_ready), 32'h4);
        step();
        arb_if.req_valid = '0;
        #1;
        chk("eng_start", 32'(arb_if.eng_start), 32'd1);
        step();
        step();
        #1;
        chk("busy", 32'(arb_if.busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk_reset_vals();
        arb_if.eng_done     = 1'b1;
        arb_if.eng_code     = 16'h1234;
        arb_if.eng_code_len = 8'd9;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("late rsp_valid", 32'(arb_if.rsp_valid), 32'd0);
            chk("late busy",      32'(arb_if.busy),      32'd0);
            chk("late eng_start", 32'(arb_if.eng_start), 32'd0);
        end
        arb_if.eng_done = 1'b0;
        run_txn('{1'b0, 4'b1111, 0, 16'd11, 4'd1, 2, 0, 1'b0}, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
